// File: rtl/axis_uart_rx.sv
// axis_uart_rx: serial-to-AXI4-Stream UART receiver, MSB first.
//   clk, rst_n   : single clock, asynchronous active-low reset
//   in           : asynchronous serial line, idle high
//   tdata/tvalid : received word on a one-entry holding register
//   tready       : downstream accept
//   framing_err  : 1-cycle pulse, stop bit sampled low (word discarded)
//   overrun      : 1-cycle pulse, new word dropped because register was full
module axis_uart_rx #(
    parameter int CLK_FREQ_HZ  = 10_000_000,
    parameter int BAUD_RATE    = 9_600,
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  framing_err,
    output logic                  overrun
);

    localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic                  sync1, rx_s;
    logic [2:0]            state, state_nxt;
    logic [CW-1:0]         bit_ctr;
    logic [DCW-1:0]        data_ctr;
    logic [DATA_WIDTH-1:0] sr;
    logic                  sample_data, deliver, frame_bad;

    // Two-flop synchronizer, reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= in;
            rx_s  <= sync1;
        end
    end

    always_comb begin
        state_nxt   = state;
        sample_data = 1'b0;
        deliver     = 1'b0;
        frame_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // Half-bit check rejects short low glitches.
                if (bit_ctr == HALF_LAST) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_ctr == BIT_LAST) begin
                    sample_data = 1'b1;
                    if (data_ctr == DATA_LAST) state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving at stop-bit centre gives half a bit of slack
                // for a back-to-back start edge.
                if (bit_ctr == BIT_LAST) begin
                    if (rx_s) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_ctr  <= '0;
            data_ctr <= '0;
            sr       <= '0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state || sample_data ||
                state == IDLE || state == WAIT_HIGH)
                bit_ctr <= '0;
            else
                bit_ctr <= bit_ctr + 1'b1;

            if (state != DATA)
                data_ctr <= '0;
            else if (sample_data)
                data_ctr <= data_ctr + 1'b1;

            if (sample_data) sr <= {sr[DATA_WIDTH-2:0], rx_s};
        end
    end

    // Holding register: a delivery into a full register is only accepted
    // when the current word is handed off in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata       <= '0;
            tvalid      <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun     <= deliver && tvalid && !tready;
            if (deliver && (!tvalid || tready)) begin
                tdata  <= sr;
                tvalid <= 1'b1;
            end else if (tvalid && tready) begin
                tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// tb_axis_uart_rx: directed bench for axis_uart_rx at 10 clocks per bit.
module tb_axis_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] tdata;
    logic       tvalid, framing_err, overrun;

    int tests = 0;
    int errors = 0;

    axis_uart_rx #(
        .CLK_FREQ_HZ (100),
        .BAUD_RATE   (10),
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (rx_line),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (ready),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation, sampled on the falling edge.
    logic [7:0] acc_q[$];
    int         acc_cyc_q[$];
    int         fe_cnt = 0, ov_cnt = 0, rise_cnt = 0, last_rise = 0, unstable = 0;
    logic       tv_prev = 1'b0, tr_prev = 1'b0;
    logic [7:0] td_prev = '0;

    always @(negedge clk) begin
        if (tvalid && ready) begin
            acc_q.push_back(tdata);
            acc_cyc_q.push_back(cyc);
        end
        if (framing_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (tvalid && !tv_prev) begin
            rise_cnt++;
            last_rise = cyc;
        end
        if (rst_n && tv_prev && !tr_prev && tdata != td_prev) unstable++;
        tv_prev = tvalid;
        tr_prev = ready;
        td_prev = tdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits MSB first, stop bit; 10 clocks each.
    task automatic send_frame(input logic [7:0] w, input logic stop);
        logic [9:0] bits;
        bits = {1'b0, w, stop};
        for (int i = 9; i >= 0; i--) begin
            rx_line = bits[i];
            tick(10);
        end
    endtask

    int c0, fe0, ov0, rise0, acc0;

    task automatic snap;
        c0    = cyc;
        fe0   = fe_cnt;
        ov0   = ov_cnt;
        rise0 = rise_cnt;
        acc0  = acc_q.size();
    endtask

    initial begin
        // Reset values
        tick(3);
        check("rst_tdata", tdata, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        tick(5);

        // Single frame 0xA5, tvalid exactly 98 edges after the start edge
        ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        tick(20);
        check("t1_rises", rise_cnt - rise0, 1);
        check("t1_rise_cyc", last_rise - c0, 98);
        check("t1_acc_n", acc_q.size() - acc0, 1);
        if (acc_q.size() > acc0) begin
            check("t1_word", acc_q[acc0], 8'hA5);
            check("t1_acc_cyc", acc_cyc_q[acc0] - c0, 98);
        end
        check("t1_tvalid_off", tvalid, 0);
        check("t1_ferr", fe_cnt - fe0, 0);
        check("t1_ovr", ov_cnt - ov0, 0);

        // Back-to-back 0x3C, 0xC3 with backpressure until 20 cycles after first tvalid
        ready = 1'b0;
        snap();
        fork
            begin
                send_frame(8'h3C, 1'b1);
                send_frame(8'hC3, 1'b1);
            end
            begin
                tick(118);
                ready = 1'b1;
            end
        join
        tick(20);
        check("t2_acc_n", acc_q.size() - acc0, 2);
        if (acc_q.size() >= acc0 + 2) begin
            check("t2_word0", acc_q[acc0], 8'h3C);
            check("t2_acc0_cyc", acc_cyc_q[acc0] - c0, 118);
            check("t2_word1", acc_q[acc0+1], 8'hC3);
            check("t2_acc1_cyc", acc_cyc_q[acc0+1] - c0, 198);
        end
        check("t2_ovr", ov_cnt - ov0, 0);
        check("t2_stable", unstable, 0);

        // Overrun: three words into a stalled register
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        tick(5);
        check("t3_tvalid", tvalid, 1);
        check("t3_tdata", tdata, 8'h11);
        check("t3_ovr", ov_cnt - ov0, 2);
        check("t3_stable", unstable, 0);
        ready = 1'b1;
        tick(3);
        check("t3_drained", tvalid, 0);
        check("t3_acc_n", acc_q.size() - acc0, 1);
        if (acc_q.size() > acc0) check("t3_word", acc_q[acc0], 8'h11);

        // Accept and delivery in the same cycle
        ready = 1'b0;
        snap();
        fork
            begin
                send_frame(8'h81, 1'b1);
                send_frame(8'h7E, 1'b1);
            end
            begin
                tick(197);
                ready = 1'b1;
            end
        join
        tick(10);
        check("t4_acc_n", acc_q.size() - acc0, 2);
        if (acc_q.size() >= acc0 + 2) begin
            check("t4_word0", acc_q[acc0], 8'h81);
            check("t4_acc0_cyc", acc_cyc_q[acc0] - c0, 197);
            check("t4_word1", acc_q[acc0+1], 8'h7E);
            check("t4_acc1_cyc", acc_cyc_q[acc0+1] - c0, 198);
        end
        check("t4_rises", rise_cnt - rise0, 1);
        check("t4_ovr", ov_cnt - ov0, 0);

        // Framing error followed by a held-low line, then a short glitch
        snap();
        send_frame(8'hFF, 1'b0);
        tick(50);
        rx_line = 1'b1;
        tick(30);
        check("t5_ferr", fe_cnt - fe0, 1);
        check("t5_no_word", rise_cnt - rise0, 0);
        rx_line = 1'b0;
        tick(3);
        rx_line = 1'b1;
        tick(30);
        check("t5_glitch_ferr", fe_cnt - fe0, 1);
        check("t5_glitch_word", rise_cnt - rise0, 0);

        // Reset during data bit 3 of 0x5A with a word held in the register
        ready = 1'b0;
        send_frame(8'h42, 1'b1);
        check("t6_pre_tvalid", tvalid, 1);
        rx_line = 1'b0;
        tick(10);
        for (int i = 7; i >= 4; i--) begin
            logic [7:0] w;
            w = 8'h5A;
            rx_line = w[i];
            tick(i == 4 ? 5 : 10);
        end
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", tvalid, 0);
        check("t6_rst_tdata", tdata, 0);
        tick(2);
        rx_line = 1'b1;
        rst_n = 1'b1;
        tick(30);
        ready = 1'b1;
        snap();
        send_frame(8'h96, 1'b1);
        tick(20);
        check("t6_acc_n", acc_q.size() - acc0, 1);
        if (acc_q.size() > acc0) check("t6_word", acc_q[acc0], 8'h96);
        check("t6_ferr", fe_cnt - fe0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
